// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard event receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_ev_t;

    localparam int KEY_EV_W = $bits(key_ev_t);

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO; a push into a full FIFO is accepted only if a pop frees a slot that cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    assign w_wr    = i_push & (~w_full | w_pop);
    assign o_drop  = i_push & w_full & ~w_pop;

    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd];
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr] <= i_data;
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into key events, queues them in a FIFO.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 20000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        rd_en,
    input  logic                        clr_err,
    output logic                        ev_valid,
    output logic [7:0]                  ev_code,
    output logic                        ev_brk,
    output logic                        ev_ext,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        err_parity,
    output logic                        err_frame
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    ps2_state_t             r_state;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [TW-1:0]          r_tmo;
    logic                   r_ext;
    logic                   r_brk;
    logic                   r_overflow;

    logic    w_clk_s;
    logic    w_bit;
    logic    w_fall;
    logic    w_tmo;
    logic    w_stop_smp;
    logic    w_ok;
    logic    w_push;
    logic    w_drop;
    key_ev_t w_ev_in;
    key_ev_t w_head;
    logic [KEY_EV_W-1:0] w_head_bits;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_bit   = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;
    assign w_tmo   = (r_state != IDLE) & ~w_fall & (r_tmo == TW'(TIMEOUT_CYC - 1));

    // Byte is good when data+parity has an odd number of ones and stop is high.
    assign w_stop_smp = (r_state == STOP) & w_fall;
    assign w_ok       = w_stop_smp & r_par & w_bit;
    assign w_push     = w_ok & (r_shift != PS2_EXT) & (r_shift != PS2_BRK);
    assign err_parity = w_stop_smp & ~r_par;
    assign err_frame  = (w_stop_smp & ~w_bit) | w_tmo;

    assign w_ev_in.ext  = r_ext;
    assign w_ev_in.brk  = r_brk;
    assign w_ev_in.code = r_shift;

    // Line idles high; resetting the synchronisers to 1 avoids a false edge at release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tmo      <= '0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev <= w_clk_s;

            if (w_fall || r_state == IDLE)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;

            if (w_tmo) begin
                r_state <= IDLE;
                r_ext   <= 1'b0;
                r_brk   <= 1'b0;
            end else if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!w_bit) begin
                            r_state  <= DATA;
                            r_bitcnt <= '0;
                            r_par    <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_par    <= r_par ^ w_bit;
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7)
                            r_state <= PARITY;
                    end
                    PARITY: begin
                        r_par   <= r_par ^ w_bit;
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (w_ok && r_shift == PS2_EXT) begin
                            r_ext <= 1'b1;
                        end else if (w_ok && r_shift == PS2_BRK) begin
                            r_brk <= 1'b1;
                        end else begin
                            r_ext <= 1'b0;
                            r_brk <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    ps2_evt_fifo #(
        .WIDTH (KEY_EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_ev_in),
        .i_pop   (rd_en),
        .o_valid (ev_valid),
        .o_data  (w_head_bits),
        .o_count (count),
        .o_drop  (w_drop)
    );

    assign w_head  = key_ev_t'(w_head_bits);
    assign ev_code = w_head.code;
    assign ev_brk  = w_head.brk;
    assign ev_ext  = w_head.ext;

    // A fresh drop in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_overflow <= 1'b0;
        else
            r_overflow <= (r_overflow & ~clr_err) | w_drop;
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: table of frames plus latency, overflow, timeout and reset sequences.
module tb_ps2_key_event_rx;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_brk;
    logic       ev_ext;
    logic [2:0] count;
    logic       overflow;
    logic       err_parity;
    logic       err_frame;

    int n_tot = 0;
    int n_bad = 0;
    int n_par = 0;
    int n_frm = 0;

    ps2_key_event_rx #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_brk     (ev_brk),
        .ev_ext     (ev_ext),
        .count      (count),
        .overflow   (overflow),
        .err_parity (err_parity),
        .err_frame  (err_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_parity) n_par <= n_par + 1;
        if (err_frame)  n_frm <= n_frm + 1;
    end

    typedef struct {
        logic [7:0] code;
        bit         flip;
        bit         bad_stop;
        int         exp_par;
        int         exp_frm;
        bit         exp_push;
        logic [9:0] exp_ev;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] code, input bit flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(~(^code) ^ flip);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit flip, input bit bad_stop);
        send_head(code, flip);
        ps2_bit(~bad_stop);
        repeat (5) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    vec_t vecs [13];
    int   p0, f0;

    initial begin
        vecs[0]  = '{8'hF0, 0, 0, 0, 0, 0, 10'h000};
        vecs[1]  = '{8'h1C, 0, 0, 0, 0, 1, {2'b01, 8'h1C}};
        vecs[2]  = '{8'hE0, 0, 0, 0, 0, 0, 10'h000};
        vecs[3]  = '{8'hF0, 0, 0, 0, 0, 0, 10'h000};
        vecs[4]  = '{8'h75, 0, 0, 0, 0, 1, {2'b11, 8'h75}};
        vecs[5]  = '{8'h1B, 0, 0, 0, 0, 1, {2'b00, 8'h1B}};
        vecs[6]  = '{8'h1B, 1, 0, 1, 0, 0, 10'h000};
        vecs[7]  = '{8'hF0, 1, 0, 1, 0, 0, 10'h000};
        vecs[8]  = '{8'h1C, 0, 0, 0, 0, 1, {2'b00, 8'h1C}};
        vecs[9]  = '{8'hE0, 0, 0, 0, 0, 0, 10'h000};
        vecs[10] = '{8'h2A, 0, 1, 0, 1, 0, 10'h000};
        vecs[11] = '{8'h2B, 0, 0, 0, 0, 1, {2'b00, 8'h2B}};
        vecs[12] = '{8'hE0, 0, 0, 0, 0, 0, 10'h000};

        // reset state
        repeat (4) @(negedge clk);
        chk("rst_valid", ev_valid, 0);
        chk("rst_ev", {ev_ext, ev_brk, ev_code}, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_errs", {err_parity, err_frame}, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // single 1C frame with exact push latency
        send_head(8'h1C, 0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat_early_valid", ev_valid, 0);
        @(negedge clk);
        chk("lat_valid", ev_valid, 1);
        chk("lat_ev", {ev_ext, ev_brk, ev_code}, {2'b00, 8'h1C});
        chk("lat_count", count, 1);
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        pop();
        chk("lat_pop_count", count, 0);
        chk("lat_pop_valid", ev_valid, 0);

        // table of frames
        for (int i = 0; i < 13; i++) begin
            p0 = n_par;
            f0 = n_frm;
            send_frame(vecs[i].code, vecs[i].flip, vecs[i].bad_stop);
            chk($sformatf("v%0d_par", i), n_par - p0, vecs[i].exp_par);
            chk($sformatf("v%0d_frm", i), n_frm - f0, vecs[i].exp_frm);
            chk($sformatf("v%0d_valid", i), ev_valid, vecs[i].exp_push);
            if (vecs[i].exp_push) begin
                chk($sformatf("v%0d_ev", i), {ev_ext, ev_brk, ev_code}, vecs[i].exp_ev);
                chk($sformatf("v%0d_count", i), count, 1);
                pop();
                chk($sformatf("v%0d_pop", i), count, 0);
            end
        end

        // timeout mid-frame (E0 above leaves ext set; timeout must clear it)
        f0 = n_frm;
        for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        repeat (TMO + 2) @(negedge clk);
        chk("tmo_frm", n_frm - f0, 1);
        chk("tmo_count", count, 0);
        send_frame(8'h1B, 0, 0);
        chk("tmo_next_valid", ev_valid, 1);
        chk("tmo_next_ev", {ev_ext, ev_brk, ev_code}, {2'b00, 8'h1B});
        pop();

        // overflow on depth-4 FIFO
        send_frame(8'h11, 0, 0);
        send_frame(8'h22, 0, 0);
        send_frame(8'h33, 0, 0);
        send_frame(8'h44, 0, 0);
        chk("ovf_pre", overflow, 0);
        send_frame(8'h55, 0, 0);
        chk("ovf_count", count, 4);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_rd%0d", i), ev_code, 8'h11 * (i + 1));
            pop();
        end
        chk("ovf_empty", count, 0);
        chk("ovf_sticky", overflow, 1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovf_clr", overflow, 0);

        // reset mid-frame discards the partial byte
        for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_count", count, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h5A, 0, 0);
        chk("mrst_valid", ev_valid, 1);
        chk("mrst_ev", {ev_ext, ev_brk, ev_code}, {2'b00, 8'h5A});
        chk("mrst_count1", count, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_rx.md
PS2_KEY_EVENT_RX -- requirements
Module: ps2_key_event_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000, clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on ps2_clk/ps2_data.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 ps2_clk  in  1  keyboard clock, asynchronous.
REQ-007 ps2_data  in  1  keyboard data, asynchronous.
REQ-008 rd_en  in  1  pop FIFO head.
REQ-009 clr_err  in  1  clear sticky overflow.
REQ-010 ev_valid  out  1  FIFO non-empty; head event presented.
REQ-011 ev_code  out  8  head scan code.
REQ-012 ev_brk  out  1  head is release (break) event.
REQ-013 ev_ext  out  1  head is extended (E0-prefixed) key.
REQ-014 count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 overflow  out  1  sticky: event dropped on full FIFO.
REQ-016 err_parity  out  1  one-cycle pulse: parity error.
REQ-017 err_frame  out  1  one-cycle pulse: bad stop bit or timeout.

Function
REQ-018 ps2_clk/ps2_data SHALL pass SYNC_STAGES flops; a bit is sampled on the cycle a synchronised ps2_clk 1->0 transition is detected.
REQ-019 Frame FSM SHALL have states IDLE, DATA, PARITY, STOP; 11-bit frame: start 0, 8 data LSB first, odd parity, stop 1.
REQ-020 IDLE->DATA on sampled 0; sampled 1 in IDLE ignored.
REQ-021 DATA->PARITY after 8th data bit; PARITY->STOP after parity bit; STOP->IDLE on stop bit.
REQ-022 Byte accepted only if parity odd over data+parity and stop=1.
REQ-023 Parity wrong: err_parity pulses on the stop-bit cycle, byte dropped, prefix flags cleared.
REQ-024 Stop bit 0: err_frame pulses, byte dropped, prefix flags cleared.
REQ-025 Outside IDLE, TIMEOUT_CYC cycles without a falling edge SHALL force IDLE, pulse err_frame, clear prefix flags; counter reloads on every edge.
REQ-026 Accepted 0xE0 sets ext flag, 0xF0 sets brk flag; neither pushes an event.
REQ-027 Any other accepted byte pushes {ext,brk,code} and clears both flags.
REQ-028 Push latency: event visible at head (ev_valid, count) on the cycle after the stop-bit sample cycle.
REQ-029 FIFO SHALL be show-ahead; rd_en with ev_valid pops; rd_en when empty ignored.
REQ-030 Push when full and no pop: event dropped, overflow set.
REQ-031 Simultaneous push and pop when full: both occur, count unchanged, no overflow.
REQ-032 Simultaneous push and pop when empty: push occurs, pop ignored.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH; order strictly FIFO.
REQ-034 clr_err clears overflow; new overflow in same cycle wins (overflow stays 1).

Reset
REQ-035 On rst low: FSM IDLE, bit/timeout counters 0, prefix flags 0, FIFO empty, count 0, ev_valid/ev_code/ev_brk/ev_ext/overflow/err_parity/err_frame 0.
REQ-036 Reset mid-frame SHALL discard the partial frame; after release the next start bit begins a fresh frame.

Structure
REQ-037 Package ps2_pkg SHALL hold FSM state enum, constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0, and the key-event struct {ext,brk,code}.
REQ-038 FIFO SHALL be sub-module ps2_evt_fifo, parameterised by width and depth.

Verification
REQ-039 Frame 0x1C -> next cycle ev_valid=1, ev_code=1C, ev_brk=0, ev_ext=0, count=1.
REQ-040 Frames F0,1C -> exactly one event: code 1C, brk=1, ext=0.
REQ-041 Frames E0,F0,75 -> one event: code 75, ext=1, brk=1; next plain 1B has ext=0, brk=0.
REQ-042 Frame 0x1B with flipped parity -> err_parity one cycle, count unchanged; then F0 with bad parity followed by 1C -> event brk=0.
REQ-043 FIFO_DEPTH=4, frames 11,22,33,44,55, rd_en=0 -> count=4, overflow=1; reads return 11,22,33,44; clr_err clears overflow.
REQ-044 4 bits of a frame then TIMEOUT_CYC+2 cycles idle -> one err_frame pulse; following frame 0x1B decodes to code 1B.
